// File: rtl/sync_fifo_pkg.sv
// Shared width helpers for the sync_fifo_rv FIFO and its pointer sub-module.
package sync_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular-buffer pointer with explicit DEPTH-1 -> 0 wrap (DEPTH need not be a power of two).
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_inc,
  output logic [ptr_w(DEPTH)-1:0] o_ptr
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_rv.sv
// Valid/ready circular-buffer FIFO with occupancy count and almost-full flag.
// Optional zero-latency empty bypass when SYNC_FIFO_BYPASS_EN is defined.
module sync_fifo_rv
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int BITS      = 64,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [BITS-1:0]         i_in_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [BITS-1:0]         o_out_data,
  output logic [cnt_w(DEPTH)-1:0] o_count,
  output logic                    o_almost_full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [BITS-1:0] r_mem [DEPTH];
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_wr_ptr;
  logic [PW-1:0]   w_rd_ptr;
  logic            w_empty;
  logic            w_full;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef SYNC_FIFO_BYPASS_EN
  assign w_bypass = w_empty && i_in_valid && !i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign o_in_ready    = !w_full;
  assign o_out_valid   = !w_empty || w_bypass;
  assign o_out_data    = w_bypass ? i_in_data : r_mem[w_rd_ptr];
  assign o_count       = r_count;
  assign o_almost_full = (int'(r_count) >= AF_THRESH);

  // A bypassed word taken by the consumer in the same cycle is never stored.
  assign w_pop  = !w_empty && i_out_ready;
  assign w_push = i_in_valid && !w_full && !(w_bypass && i_out_ready);

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (i_flush),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (i_flush),
    .i_inc (w_pop),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Flush only rewinds pointers; stale storage is left in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[w_wr_ptr] <= i_in_data;
    end
  end

endmodule
